// File: rtl/crypt_pipe_rot_out.sv
// crypt_pipe_rot_out: two-stage rotating-key Caesar cipher on one-hot letters.
// Stage 1 classifies the character, selects the current key and rotates the
// one-hot letter field; stage 2 turns the rotated one-hot back into ASCII.
module crypt_pipe_rot_out #(
  parameter logic [7:0] ERR_CHAR = 8'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        is_alpha_upper_case,
  input  logic        is_alpha_low_case,
  input  logic [31:0] extended_shift_data,
  input  logic [7:0]  k1,
  input  logic [7:0]  k2,
  input  logic [7:0]  k3,
  input  logic [2:0]  rot_freq,
  input  logic        mode,
  output logic        en_out,
  output logic [7:0]  dout,
  output logic        err_out
);

  // ---------------- stage 1: classify, pick key, rotate ----------------
  logic [25:0] w_field;
  logic        w_onehot;
  logic        w_any_flag;
  logic        w_good_alpha;
  logic        w_malformed;
  logic [7:0]  w_key;
  logic [4:0]  w_shift;
  logic [51:0] w_dbl;
  logic [51:0] w_dbl_fwd;
  logic [51:0] w_dbl_bwd;
  logic [25:0] w_rotated;
  logic [3:0]  w_cnt_next;

  assign w_field      = extended_shift_data[31:6];
  assign w_onehot     = (w_field != 26'd0) && ((w_field & (w_field - 26'd1)) == 26'd0);
  assign w_any_flag   = is_alpha_upper_case | is_alpha_low_case;
  assign w_good_alpha = w_any_flag & ~(is_alpha_upper_case & is_alpha_low_case) & w_onehot;
  assign w_malformed  = w_any_flag & ~w_good_alpha;

  logic [1:0] r_key_idx;
  logic [2:0] r_alpha_cnt;

  assign w_key   = (r_key_idx == 2'd0) ? k1 : (r_key_idx == 2'd1) ? k2 : k3;
  assign w_shift = 5'(w_key % 8'd26);

  // Doubling the field turns a cyclic rotate into a plain shift plus a slice.
  assign w_dbl     = {w_field, w_field};
  assign w_dbl_fwd = w_dbl << w_shift;
  assign w_dbl_bwd = w_dbl >> w_shift;
  assign w_rotated = mode ? w_dbl_bwd[25:0] : w_dbl_fwd[51:26];

  assign w_cnt_next = {1'b0, r_alpha_cnt} + 4'd1;

  // Key schedule: advances only on well-formed alpha characters.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_idx   <= 2'd0;
      r_alpha_cnt <= 3'd0;
    end else if (en && w_good_alpha) begin
      if (rot_freq == 3'd0) begin
        r_key_idx   <= 2'd0;
        r_alpha_cnt <= 3'd0;
      end else if (w_cnt_next >= {1'b0, rot_freq}) begin
        r_alpha_cnt <= 3'd0;
        r_key_idx   <= (r_key_idx == 2'd2) ? 2'd0 : r_key_idx + 2'd1;
      end else begin
        r_alpha_cnt <= w_cnt_next[2:0];
      end
    end
  end

  logic        r_s1_valid;
  logic        r_s1_alpha;
  logic        r_s1_upper;
  logic        r_s1_err;
  logic [25:0] r_s1_data;

  // Stage-1 register: valid always tracks en, data loads only on valid chars.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_alpha <= 1'b0;
      r_s1_upper <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_data  <= 26'd0;
    end else begin
      r_s1_valid <= en;
      if (en) begin
        r_s1_alpha <= w_good_alpha;
        r_s1_upper <= is_alpha_upper_case;
        r_s1_err   <= w_malformed;
        r_s1_data  <= w_good_alpha ? w_rotated : {18'd0, extended_shift_data[7:0]};
      end
    end
  end

  // ---------------- stage 2: one-hot to ASCII ----------------
  logic [4:0] w_idx;
  logic [7:0] w_char;

  // One-hot to binary index of the rotated letter.
  // NOTE: the default assignment before the loop keeps this purely
  // combinational; without it a path that assigns nothing infers a latch.
  always_comb begin
    w_idx = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (r_s1_data[i]) w_idx = 5'(i);
    end
  end

  // Select the output byte for the character held in stage 1.
  always_comb begin
    w_char = r_s1_data[7:0];
    if (r_s1_err)
      w_char = ERR_CHAR;
    else if (r_s1_alpha)
      w_char = (r_s1_upper ? 8'd65 : 8'd97) + {3'd0, w_idx};
  end

  logic       r_en_out;
  logic [7:0] r_dout;
  logic       r_err;

  // Output register: data loads only for valid characters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_out <= 1'b0;
      r_dout   <= 8'd0;
      r_err    <= 1'b0;
    end else begin
      r_en_out <= r_s1_valid;
      if (r_s1_valid) begin
        r_dout <= w_char;
        r_err  <= r_s1_err;
      end
    end
  end

  // Bubbles read as zero without disturbing the held data.
  assign en_out  = r_en_out;
  assign dout    = r_en_out ? r_dout : 8'd0;
  assign err_out = r_en_out & r_err;

endmodule

// File: tb/tb_crypt_pipe_rot_out.sv
// Self-checking bench for crypt_pipe_rot_out: directed vectors with golden
// bytes plus randomized traffic against a letter-arithmetic reference model.
module tb_crypt_pipe_rot_out;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        up;
  logic        lo;
  logic [31:0] data;
  logic [7:0]  k1, k2, k3;
  logic [2:0]  rf;
  logic        mode;
  logic        en_out;
  logic [7:0]  dout;
  logic        err_out;

  int checks   = 0;
  int failures = 0;

  // Reference key schedule, expressed as "which key" and "letters so far".
  int m_idx = 0;
  int m_cnt = 0;

  typedef struct {
    logic       en;
    logic [7:0] dout;
    logic       err;
    int         gold;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  crypt_pipe_rot_out #(.ERR_CHAR(8'h3F)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .en                  (en),
    .is_alpha_upper_case (up),
    .is_alpha_low_case   (lo),
    .extended_shift_data (data),
    .k1                  (k1),
    .k2                  (k2),
    .k3                  (k3),
    .rot_freq            (rf),
    .mode                (mode),
    .en_out              (en_out),
    .dout                (dout),
    .err_out             (err_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] letter(input int i);
    return 32'd1 << (6 + i);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: alphabet position arithmetic on the letter index.
  function automatic exp_t predict(input logic t_en, input logic t_up,
                                   input logic t_lo, input logic [31:0] d);
    exp_t e;
    logic [25:0] f;
    int li, key, s, n;
    e.en = 1'b0; e.dout = 8'd0; e.err = 1'b0; e.gold = -1; e.tag = "";
    if (!t_en) return e;
    e.en = 1'b1;
    f = d[31:6];
    if (!t_up && !t_lo) begin
      e.dout = d[7:0];
    end else if ((t_up && t_lo) || $countones(f) != 1) begin
      e.dout = 8'h3F;
      e.err  = 1'b1;
    end else begin
      li = 0;
      for (int i = 0; i < 26; i++) if (f[i]) li = i;
      key = (m_idx == 0) ? int'(k1) : (m_idx == 1) ? int'(k2) : int'(k3);
      s = key % 26;
      n = mode ? (li - s + 26) % 26 : (li + s) % 26;
      e.dout = 8'((t_up ? 65 : 97) + n);
      if (rf == 3'd0) begin
        m_idx = 0;
        m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt >= int'(rf)) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % 3;
        end
      end
    end
    return e;
  endfunction

  // One cycle: check the character from two cycles ago, drive a new one,
  // return just after the capturing edge so keys may be changed safely.
  task automatic step(input string tag, input logic t_en, input logic t_up,
                      input logic t_lo, input logic [31:0] d, input int gold);
    exp_t e, o;
    @(negedge clk);
    if (exp_q.size() == 2) begin
      o = exp_q.pop_front();
      chk({o.tag, " en_out"}, {7'd0, en_out}, {7'd0, o.en});
      chk({o.tag, " dout"}, dout, o.dout);
      chk({o.tag, " err_out"}, {7'd0, err_out}, {7'd0, o.err});
      if (o.gold >= 0) chk({o.tag, " golden"}, dout, 8'(o.gold));
    end
    en = t_en; up = t_up; lo = t_lo; data = d;
    e = predict(t_en, t_up, t_lo, d);
    e.tag  = tag;
    e.gold = gold;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step("idle", 1'b0, 1'b0, 1'b0, 32'd0, -1);
  endtask

  task automatic flush();
    idle(); idle(); idle();
  endtask

  // Asynchronous reset for one cycle; outputs must clear without an edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, " async en_out"}, {7'd0, en_out}, 8'd0);
    chk({tag, " async dout"}, dout, 8'd0);
    chk({tag, " async err_out"}, {7'd0, err_out}, 8'd0);
    @(posedge clk);
    #1;
    chk({tag, " held en_out"}, {7'd0, en_out}, 8'd0);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    m_idx = 0;
    m_cnt = 0;
  endtask

  initial begin
    // Reset at power-up with junk on the inputs.
    rst = 1'b0; en = 1'b1; up = 1'b1; lo = 1'b0; data = letter(3);
    k1 = 8'd3; k2 = 8'd0; k3 = 8'd0; rf = 3'd0; mode = 1'b0;
    #2;
    chk("por en_out", {7'd0, en_out}, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("por dout", dout, 8'd0);
    chk("por err_out", {7'd0, err_out}, 8'd0);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;

    // Basic encrypt, decrypt with wrap, key modulo 26.
    k1 = 8'd3; rf = 3'd0; mode = 1'b0;
    step("enc A k3", 1'b1, 1'b1, 1'b0, letter(0), 8'h44);
    chk("first en_out latency", {7'd0, en_out}, 8'd0);
    mode = 1'b1;
    step("dec b k3", 1'b1, 1'b0, 1'b1, letter(1), 8'h79);
    mode = 1'b0; k1 = 8'd29;
    step("enc A k29", 1'b1, 1'b1, 1'b0, letter(0), 8'h44);
    k1 = 8'd255;
    step("enc z k255", 1'b1, 1'b0, 1'b1, letter(25) | 32'h3F, -1);
    flush();

    // Key schedule, back-to-back.
    do_reset("rst1");
    rf = 3'd2; k1 = 8'd1; k2 = 8'd2; k3 = 8'd3; mode = 1'b0;
    step("sched 1", 1'b1, 1'b1, 1'b0, letter(0), 8'h42);
    step("sched 2", 1'b1, 1'b1, 1'b0, letter(0), 8'h42);
    step("sched 3", 1'b1, 1'b1, 1'b0, letter(0), 8'h43);
    step("sched 4", 1'b1, 1'b1, 1'b0, letter(0), 8'h43);
    step("sched 5", 1'b1, 1'b1, 1'b0, letter(0), 8'h44);
    step("sched 6", 1'b1, 1'b1, 1'b0, letter(0), 8'h44);
    step("sched 7", 1'b1, 1'b1, 1'b0, letter(0), 8'h42);
    flush();

    // Same schedule with non-alpha, bubbles and malformed characters mixed in.
    do_reset("rst2");
    step("mix A1", 1'b1, 1'b1, 1'b0, letter(0), 8'h42);
    step("mix A2", 1'b1, 1'b1, 1'b0, letter(0), 8'h42);
    step("mix 5", 1'b1, 1'b0, 1'b0, 32'h0000_0035, 8'h35);
    idle();
    step("mix A3", 1'b1, 1'b1, 1'b0, letter(0), 8'h43);
    step("mix zero field", 1'b1, 1'b1, 1'b0, 32'h0000_0015, 8'h3F);
    step("mix A4", 1'b1, 1'b1, 1'b0, letter(0), 8'h43);
    step("mix A5", 1'b1, 1'b1, 1'b0, letter(0), 8'h44);
    idle();
    step("mix two bits", 1'b1, 1'b1, 1'b0, letter(0) | letter(1), 8'h3F);
    step("mix A6", 1'b1, 1'b1, 1'b0, letter(0), 8'h44);
    step("mix both flags", 1'b1, 1'b1, 1'b1, letter(0), 8'h3F);
    step("mix A7", 1'b1, 1'b1, 1'b0, letter(0), 8'h42);
    flush();

    // Reset mid-stream: in-flight characters vanish, key schedule restarts.
    rf = 3'd2; k1 = 8'd1; k2 = 8'd7; k3 = 8'd11;
    step("pre A1", 1'b1, 1'b1, 1'b0, letter(0), -1);
    step("pre A2", 1'b1, 1'b1, 1'b0, letter(0), -1);
    step("pre A3", 1'b1, 1'b1, 1'b0, letter(0), -1);
    do_reset("rst3");
    idle();
    chk("dropped en_out", {7'd0, en_out}, 8'd0);
    step("post A", 1'b1, 1'b1, 1'b0, letter(0), 8'h42);
    chk("post latency en_out", {7'd0, en_out}, 8'd0);
    flush();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      int kind;
      logic t_en, t_up, t_lo;
      logic [31:0] d;
      k1 = 8'($urandom); k2 = 8'($urandom); k3 = 8'($urandom);
      rf = 3'($urandom_range(0, 7));
      mode = 1'($urandom);
      t_en = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 9);
      d = {26'd0, 6'($urandom)} | letter($urandom_range(0, 25));
      t_up = 1'b0; t_lo = 1'b0;
      case (kind)
        0, 1, 2, 3: t_up = 1'b1;
        4, 5, 6:    t_lo = 1'b1;
        7:          d = $urandom;
        8: begin
          t_up = 1'($urandom);
          t_lo = ~t_up;
          d = ($urandom_range(0, 1) == 0) ? {26'd0, 6'($urandom)}
                                          : (d | letter($urandom_range(0, 25)) | letter(25));
        end
        default: begin t_up = 1'b1; t_lo = 1'b1; end
      endcase
      step("rand", t_en, t_up, t_lo, d, -1);
    end
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
